// File: rtl/t03_timer_pkg.sv
// -----------------------------------------------------------------------------
// t03_timer_pkg
// Shared definitions for the hardware-clock timer controller:
//   - MMIO word addresses (CTRL..CAPTURE)
//   - counting modes and a decoder that folds the unused mode code onto
//     free-run
//   - CTRL / STATUS bit positions
//   - bus FSM state type
// -----------------------------------------------------------------------------
package t03_timer_pkg;

  typedef enum logic [2:0] {
    ADDR_CTRL     = 3'd0,
    ADDR_PRESCALE = 3'd1,
    ADDR_COUNT    = 3'd2,
    ADDR_COMPARE  = 3'd3,
    ADDR_STATUS   = 3'd4,
    ADDR_CAPTURE  = 3'd5
  } reg_addr_e;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10
  } mode_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_MODE_LSB    = 1;
  localparam int CTRL_MODE_MSB    = 2;
  localparam int CTRL_IRQ_EN_BIT  = 3;
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_CAP_BIT   = 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  // Mode code 2'b11 behaves exactly like free-run.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = MODE_PERIODIC;
      2'b10:   m = MODE_ONESHOT;
      default: m = MODE_FREE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/t03_timer_prescaler.sv
// -----------------------------------------------------------------------------
// t03_timer_prescaler
// Divides the system clock into count ticks. While en is high the internal
// counter steps every cycle; on the cycle it equals reload it wraps to 0 and
// tick is high for that cycle. reload = 0 therefore ticks every cycle.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        run enable (low freezes the counter)
//   clr       synchronous clear (a write of the reload register); no tick
//   reload    terminal count
//   tick      one-cycle count strobe
// -----------------------------------------------------------------------------
module t03_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_at_reload;

  assign w_at_reload = (r_cnt == reload);
  // A clear in the same cycle suppresses the strobe so the new reload
  // value always starts from a full period.
  assign tick = en && !clr && w_at_reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_at_reload) r_cnt <= '0;
      else             r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/t03_hwclk_timer_ctrl.sv
// -----------------------------------------------------------------------------
// t03_hwclk_timer_ctrl
// Programmable timer producing the free-running hardware-clock counter.
// Software drives it through a small MMIO register file with a
// request / one-cycle-ack handshake; a compare match raises a level irq.
//
// Optional feature macro: T03_TIMER_CAPTURE_EN
//   adds capture_in (async, 2-flop synchronised); a rising edge latches
//   COUNT into CAPTURE and sets STATUS[1]. Without it address 5 and
//   STATUS[1] read 0.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mmio_addr     word select (0 CTRL,1 PRESCALE,2 COUNT,3 COMPARE,
//                 4 STATUS,5 CAPTURE,6-7 reserved)
//   mmio_ren/wen  request strobes, held until mmio_ack
//   mmio_wdata    write data
//   mmio_rdata    registered read data, valid with mmio_ack
//   mmio_ack      one-cycle response
//   counter_out   live COUNT value
//   irq           STATUS flags gated by CTRL.irq_en
//   capture_in    (macro only) asynchronous capture strobe
// -----------------------------------------------------------------------------
module t03_hwclk_timer_ctrl
  import t03_timer_pkg::*;
#(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mmio_addr,
  input  logic        mmio_ren,
  input  logic        mmio_wen,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ack,
  output logic [31:0] counter_out,
  output logic        irq
`ifdef T03_TIMER_CAPTURE_EN
 ,input  logic        capture_in
`endif
);

  // ---------------------------------------------------------------- bus FSM
  bus_state_e r_state;
  bus_state_e w_state_next;
  logic       w_access;
  logic       w_wr;
  logic       w_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BUS_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUS_IDLE: if (mmio_ren || mmio_wen) w_state_next = BUS_RESP;
      BUS_RESP: w_state_next = BUS_IDLE;
      default:  w_state_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    mmio_ack = (r_state == BUS_RESP);
  end

  // Accesses are only taken in IDLE; requests still held during RESP are
  // ignored. Write has priority over read when both strobes are set.
  assign w_access = (r_state == BUS_IDLE) && (mmio_ren || mmio_wen);
  assign w_wr     = w_access && mmio_wen;
  assign w_rd     = w_access && mmio_ren && !mmio_wen;

  logic w_wr_ctrl, w_wr_prescale, w_wr_count, w_wr_compare, w_wr_status;
  assign w_wr_ctrl     = w_wr && (mmio_addr == ADDR_CTRL);
  assign w_wr_prescale = w_wr && (mmio_addr == ADDR_PRESCALE);
  assign w_wr_count    = w_wr && (mmio_addr == ADDR_COUNT);
  assign w_wr_compare  = w_wr && (mmio_addr == ADDR_COMPARE);
  assign w_wr_status   = w_wr && (mmio_addr == ADDR_STATUS);

  // --------------------------------------------------------------- registers
  logic                  r_ctrl_en;
  logic [1:0]            r_ctrl_mode;
  logic                  r_ctrl_irq_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_match;
  logic [31:0]           r_rdata;

  logic                  w_tick;
  logic                  w_hit;
  mode_e                 w_mode;
  logic                  w_cap_flag;
  logic [31:0]           w_capture_word;

  t03_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (r_ctrl_en),
    .clr    (w_wr_prescale),
    .reload (r_prescale),
    .tick   (w_tick)
  );

  assign w_mode = decode_mode(r_ctrl_mode);
  // A software COUNT write in the tick cycle overrides the count step and
  // suppresses match evaluation entirely.
  assign w_hit  = w_tick && !w_wr_count && (r_count == r_compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_en     <= 1'b0;
      r_ctrl_mode   <= 2'b00;
      r_ctrl_irq_en <= 1'b0;
      r_prescale    <= '0;
      r_count       <= '0;
      r_compare     <= RESET_COMPARE;
      r_match       <= 1'b0;
    end else begin
      // Software write beats the one-shot auto-disable.
      if (w_wr_ctrl) begin
        r_ctrl_en     <= mmio_wdata[CTRL_EN_BIT];
        r_ctrl_mode   <= mmio_wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_ctrl_irq_en <= mmio_wdata[CTRL_IRQ_EN_BIT];
      end else if (w_hit && (w_mode == MODE_ONESHOT)) begin
        r_ctrl_en <= 1'b0;
      end

      if (w_wr_prescale) r_prescale <= mmio_wdata[PRESCALE_W-1:0];

      if (w_wr_count) begin
        r_count <= mmio_wdata;
      end else if (w_tick) begin
        if (w_hit) begin
          case (w_mode)
            MODE_PERIODIC: r_count <= '0;
            MODE_ONESHOT:  r_count <= r_count;
            default:       r_count <= r_count + 32'd1;
          endcase
        end else begin
          r_count <= r_count + 32'd1;
        end
      end

      if (w_wr_compare) r_compare <= mmio_wdata;

      // New match has priority over write-1-to-clear.
      if (w_hit)                                         r_match <= 1'b1;
      else if (w_wr_status && mmio_wdata[STATUS_MATCH_BIT]) r_match <= 1'b0;
    end
  end

  // ---------------------------------------------------------- capture path
`ifdef T03_TIMER_CAPTURE_EN
  logic [1:0]  r_cap_sync;
  logic        r_cap_prev;
  logic [31:0] r_capture;
  logic        r_cap_flag;
  logic        w_cap_edge;

  assign w_cap_edge = r_cap_sync[1] && !r_cap_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_sync <= 2'b00;
      r_cap_prev <= 1'b0;
      r_capture  <= '0;
      r_cap_flag <= 1'b0;
    end else begin
      r_cap_sync <= {r_cap_sync[0], capture_in};
      r_cap_prev <= r_cap_sync[1];
      if (w_cap_edge) r_capture <= r_count;
      if (w_cap_edge)                                      r_cap_flag <= 1'b1;
      else if (w_wr_status && mmio_wdata[STATUS_CAP_BIT]) r_cap_flag <= 1'b0;
    end
  end

  assign w_cap_flag     = r_cap_flag;
  assign w_capture_word = r_capture;
`else
  assign w_cap_flag     = 1'b0;
  assign w_capture_word = '0;
`endif

  // ------------------------------------------------------------- read path
  logic [31:0] w_rd_val;

  always_comb begin
    w_rd_val = '0;
    case (mmio_addr)
      ADDR_CTRL:     w_rd_val = {28'd0, r_ctrl_irq_en, r_ctrl_mode, r_ctrl_en};
      ADDR_PRESCALE: w_rd_val = 32'(r_prescale);
      ADDR_COUNT:    w_rd_val = r_count;
      ADDR_COMPARE:  w_rd_val = r_compare;
      ADDR_STATUS:   w_rd_val = {30'd0, w_cap_flag, r_match};
      ADDR_CAPTURE:  w_rd_val = w_capture_word;
      default:       w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rdata <= '0;
    else if (w_access) r_rdata <= w_rd ? w_rd_val : 32'd0;
  end

  assign mmio_rdata  = r_rdata;
  assign counter_out = r_count;
  assign irq         = r_ctrl_irq_en && (r_match || w_cap_flag);

endmodule
